frontend_cfg_tx: RTL and testbench

Serial configuration transmitter that drives the backend gain/reset sequencer's serial port. It latches a 2-bit gain for amplifier 1 and a 3-bit gain for amplifier 2 and shifts them out on a generated serial clock/data pair, preceded by one start slot. It then waits for the backend's ready flag and reports completion or timeout. The block sits in the digital control domain on `i_clk`, in front of the backend.

---
 rtl/frontend_cfg_tx.sv | 152 +++++++++++++++
 tb/tb_frontend_cfg_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_cfg_tx.sv
// Serial configuration transmitter for the backend gain/reset sequencer.
// Shifts a start slot plus five gain bits on a divided serial clock, then waits for backend ready.
module frontend_cfg_tx #(
  parameter int CLK_DIV       = 2,
  parameter int READY_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_resetbAll,
  input  logic       i_start,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  input  logic       i_ready,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = $clog2(READY_TIMEOUT);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);
  localparam logic [2:0]        LAST_SLOT = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_RDY,
    DONE,
    TOUT
  } state_t;

  state_t              state, state_nxt;
  logic [4:0]          shadow, shadow_nxt;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
  logic [2:0]          slot, slot_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                ready_meta, ready_sync;
  logic                sclk_nxt, sdin_nxt, busy_nxt, done_nxt, timeout_nxt;
  logic [5:0]          frame;

  // Slot 0 is the constant start bit; slots 1..5 carry gainA1 then gainA2, LSB first.
  assign frame = {shadow, 1'b1};

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      ready_meta <= 1'b0;
      ready_sync <= 1'b0;
    end else begin
      ready_meta <= i_ready;
      ready_sync <= ready_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state     <= IDLE;
      shadow    <= '0;
      div_cnt   <= '0;
      slot      <= '0;
      wait_cnt  <= '0;
      o_sclk    <= 1'b0;
      o_sdin    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      div_cnt   <= div_cnt_nxt;
      slot      <= slot_nxt;
      wait_cnt  <= wait_cnt_nxt;
      o_sclk    <= sclk_nxt;
      o_sdin    <= sdin_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
      o_timeout <= timeout_nxt;
    end
  end

  // Outputs are computed for the next state so they register in step with it.
  always_comb begin
    state_nxt    = state;
    shadow_nxt   = shadow;
    div_cnt_nxt  = div_cnt;
    slot_nxt     = slot;
    wait_cnt_nxt = wait_cnt;
    sclk_nxt     = 1'b0;
    sdin_nxt     = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt   = SHIFT;
          shadow_nxt  = {i_gainA2, i_gainA1};
          div_cnt_nxt = '0;
          slot_nxt    = '0;
          sdin_nxt    = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        sclk_nxt = o_sclk;
        sdin_nxt = o_sdin;
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (!o_sclk) begin
            sclk_nxt = 1'b1;
          end else if (slot == LAST_SLOT) begin
            state_nxt    = WAIT_RDY;
            wait_cnt_nxt = '0;
            sclk_nxt     = 1'b0;
            sdin_nxt     = 1'b0;
          end else begin
            // New data is launched together with the falling edge.
            slot_nxt = slot + 3'd1;
            sclk_nxt = 1'b0;
            sdin_nxt = frame[slot + 3'd1];
          end
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      WAIT_RDY: begin
        busy_nxt = 1'b1;
        if (ready_sync) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = TOUT;
          timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      TOUT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frontend_cfg_tx.sv
// Scoreboard bench for frontend_cfg_tx: three instances (N=2, N=1, N=5) checked by one monitor
// that decodes each frame from the serial pins and compares it to a queued expectation.
`timescale 1ns/1ps
module tb_frontend_cfg_tx;

  localparam int N0 = 2;
  localparam int N1 = 1;
  localparam int N2 = 5;
  localparam int T0 = 64;
  localparam int T12 = 8;

  typedef struct {
    logic [5:0] bits;
    int         busy_len;
    int         want_done;
    int         want_tout;
    bit         check_bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [3];
  logic [1:0] g1 [3];
  logic [2:0] g2 [3];
  logic       ready_s [3];
  logic       sclk [3];
  logic       sdin [3];
  logic       busy [3];
  logic       done [3];
  logic       tout [3];
  logic       bk_en = 1'b0;
  logic       bk_ready = 1'b0;
  logic       ready0_w;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q [3][$];

  assign ready0_w = bk_en ? bk_ready : ready_s[0];

  always #5 clk = ~clk;

  frontend_cfg_tx #(.CLK_DIV(N0), .READY_TIMEOUT(T0)) u_dut0 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(start_s[0]), .i_gainA1(g1[0]), .i_gainA2(g2[0]),
    .i_ready(ready0_w), .o_sclk(sclk[0]), .o_sdin(sdin[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_timeout(tout[0]));

  frontend_cfg_tx #(.CLK_DIV(N1), .READY_TIMEOUT(T12)) u_dut1 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(start_s[1]), .i_gainA1(g1[1]), .i_gainA2(g2[1]),
    .i_ready(ready_s[1]), .o_sclk(sclk[1]), .o_sdin(sdin[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_timeout(tout[1]));

  frontend_cfg_tx #(.CLK_DIV(N2), .READY_TIMEOUT(T12)) u_dut2 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(start_s[2]), .i_gainA1(g1[2]), .i_gainA2(g2[2]),
    .i_ready(ready_s[2]), .o_sclk(sclk[2]), .o_sdin(sdin[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_timeout(tout[2]));

  function automatic int nOf(input int d);
    return (d == 0) ? N0 : ((d == 1) ? N1 : N2);
  endfunction

  function automatic int toOf(input int d);
    return (d == 0) ? T0 : T12;
  endfunction

  task automatic checkOutput(input string name, input int d, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s dut%0d: got %0d expected %0d", name, d, actual, expected);
    end
  endtask

  // mode 0: ready high -> done; 1: ready low -> timeout; 2: backend-driven done; 3: aborted by reset
  task automatic applyStimulus(input int d, input logic [1:0] a1, input logic [2:0] a2, input int mode);
    exp_t e;
    e.bits       = {a2, a1, 1'b1};
    e.busy_len   = (mode == 0) ? 12 * nOf(d) + 2 : ((mode == 1) ? 12 * nOf(d) + toOf(d) + 1 : 0);
    e.want_done  = (mode == 0 || mode == 2) ? 1 : 0;
    e.want_tout  = (mode == 1) ? 1 : 0;
    e.check_bits = (mode != 3);
    @(posedge clk);
    #1;
    g1[d] = a1;
    g2[d] = a2;
    start_s[d] = 1'b1;
    exp_q[d].push_back(e);
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    g1[d] = 2'($urandom);
    g2[d] = 3'($urandom);
  endtask

  task automatic pulseIgnored(input int d, input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    start_s[d] = 1'b1;
    g1[d] = ~g1[d];
    g2[d] = ~g2[d];
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
  endtask

  task automatic waitIdle(input int d);
    int k = 0;
    while (busy[d] !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) checkOutput("idle_wait", d, 0, 1);
  endtask

  int         rises [3];
  int         blen [3];
  int         dcnt [3];
  int         tcnt [3];
  int         pulse_at [3];
  int         glitch [3];
  int         stray [3];
  logic [5:0] cap [3];
  logic       p_sclk [3];
  logic       p_sdin [3];
  logic       p_busy [3];

  task automatic monitorStep(input int d);
    exp_t e;
    if (busy[d] === 1'b1) begin
      if (p_busy[d] !== 1'b1) begin
        rises[d] = 0; cap[d] = '0; blen[d] = 0; dcnt[d] = 0; tcnt[d] = 0;
        pulse_at[d] = -1; glitch[d] = 0;
      end
      blen[d]++;
      if (sclk[d] === 1'b1 && p_sclk[d] !== 1'b1) begin
        if (rises[d] < 6) cap[d][rises[d]] = sdin[d];
        rises[d]++;
      end
      if (sclk[d] === 1'b1 && p_sclk[d] === 1'b1 && sdin[d] !== p_sdin[d]) glitch[d]++;
      if (done[d] === 1'b1) begin dcnt[d]++; pulse_at[d] = blen[d] - 1; end
      if (tout[d] === 1'b1) begin tcnt[d]++; pulse_at[d] = blen[d] - 1; end
    end else begin
      if (done[d] === 1'b1 || tout[d] === 1'b1) stray[d]++;
      if (p_busy[d] === 1'b1) begin
        checkOutput("frame_expected", d, (exp_q[d].size() > 0) ? 1 : 0, 1);
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          if (e.check_bits) begin
            checkOutput("rise_count", d, rises[d], 6);
            checkOutput("frame_bits", d, int'(cap[d]), int'(e.bits));
            checkOutput("sdin_stable_high", d, glitch[d], 0);
          end
          checkOutput("done_pulses", d, dcnt[d], e.want_done);
          checkOutput("tout_pulses", d, tcnt[d], e.want_tout);
          if (e.busy_len > 0) begin
            checkOutput("busy_cycles", d, blen[d], e.busy_len);
            checkOutput("pulse_position", d, pulse_at[d], e.busy_len - 1);
          end
        end
      end
    end
    p_sclk[d] = sclk[d];
    p_sdin[d] = sdin[d];
    p_busy[d] = busy[d];
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rises[d] = 0; blen[d] = 0; dcnt[d] = 0; tcnt[d] = 0; pulse_at[d] = -1;
      glitch[d] = 0; stray[d] = 0; cap[d] = '0;
      p_sclk[d] = 1'b0; p_sdin[d] = 1'b0; p_busy[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) monitorStep(d);
    end
  end

  // Receiver model: captures six bits on sclk rises, decodes gains, answers ready a little later.
  logic [5:0] bk_bits = '0;
  int         bk_n = 0;
  int         bk_delay = -1;
  logic       bk_prev = 1'b0;
  logic [1:0] bk_exp1 = '0;
  logic [2:0] bk_exp2 = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (bk_en) begin
        if (sclk[0] === 1'b1 && bk_prev !== 1'b1 && bk_n < 6) begin
          bk_bits[bk_n] = sdin[0];
          bk_n++;
          if (bk_n == 6) begin
            checkOutput("backend_gainA1", 0, int'(bk_bits[2:1]), int'(bk_exp1));
            checkOutput("backend_gainA2", 0, int'(bk_bits[5:3]), int'(bk_exp2));
            bk_delay = 3;
          end
        end
        if (bk_delay > 0) bk_delay--;
        else if (bk_delay == 0) begin bk_ready = 1'b1; bk_delay = -1; end
        if (done[0] === 1'b1) begin bk_ready = 1'b0; bk_n = 0; end
      end
      bk_prev = sclk[0];
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int mode;
    logic [1:0] ra1;
    logic [2:0] ra2;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; g1[d] = '0; g2[d] = '0; ready_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_sclk", 0, int'(sclk[0]), 0);
    checkOutput("reset_sdin", 0, int'(sdin[0]), 0);
    checkOutput("reset_busy", 0, int'(busy[0]), 0);
    checkOutput("reset_done", 0, int'(done[0]), 0);
    checkOutput("reset_timeout", 0, int'(tout[0]), 0);

    $display("[TB] directed frame 01/110 with ready high, then back-to-back start");
    ready_s[0] = 1'b1;
    applyStimulus(0, 2'b01, 3'b110, 0);
    k = 0;
    while (done[0] !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) checkOutput("done_wait", 0, 0, 1);
    ra1 = 2'($urandom);
    ra2 = 3'($urandom);
    begin
      exp_t e;
      e.bits = {ra2, ra1, 1'b1}; e.busy_len = 12 * N0 + 2; e.want_done = 1; e.want_tout = 0; e.check_bits = 1'b1;
      exp_q[0].push_back(e);
    end
    g1[0] = ra1;
    g2[0] = ra2;
    start_s[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    waitIdle(0);

    $display("[TB] backend receiver frame 10/011");
    bk_exp1 = 2'b10;
    bk_exp2 = 3'b011;
    bk_en = 1'b1;
    applyStimulus(0, 2'b10, 3'b011, 2);
    waitIdle(0);
    @(negedge clk);
    bk_en = 1'b0;

    $display("[TB] ready held low, timeout expected");
    ready_s[0] = 1'b0;
    applyStimulus(0, 2'($urandom), 3'($urandom), 1);
    waitIdle(0);

    $display("[TB] start pulsed during slot 3 is ignored");
    ready_s[0] = 1'b1;
    applyStimulus(0, 2'b11, 3'b010, 0);
    pulseIgnored(0, 6 * N0);
    waitIdle(0);

    $display("[TB] reset asserted in slot 2");
    applyStimulus(0, 2'b10, 3'b101, 3);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sclk", 0, int'(sclk[0]), 0);
    checkOutput("abort_sdin", 0, int'(sdin[0]), 0);
    checkOutput("abort_busy", 0, int'(busy[0]), 0);
    checkOutput("abort_done", 0, int'(done[0]), 0);
    checkOutput("abort_timeout", 0, int'(tout[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2'($urandom), 3'($urandom), 0);
    waitIdle(0);

    $display("[TB] random frames on N=1 and N=5");
    for (int d = 1; d < 3; d++) begin
      for (int f = 0; f < 50; f++) begin
        waitIdle(d);
        mode = int'($urandom_range(0, 1));
        ready_s[d] = (mode == 0);
        ra1 = 2'($urandom);
        ra2 = 3'($urandom);
        applyStimulus(d, ra1, ra2, mode);
        if ($urandom_range(0, 1) == 1) pulseIgnored(d, int'($urandom_range(0, 12 * nOf(d) - 3)));
      end
      waitIdle(d);
    end

    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("queue_drained", d, exp_q[d].size(), 0);
      checkOutput("stray_pulses", d, stray[d], 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
